// File: rtl/clkmon_pkg.sv
// Shared types and default build constants for the PLL clock monitor
// (12 MHz reference, 48 MHz core).
package clkmon_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2,
      LOCKED  = 2'd3
   } clkmon_state_t;

   localparam int DEF_REF_EDGES  = 64;
   localparam int DEF_EXPECTED   = 256;
   localparam int DEF_TOLERANCE  = 2;
   localparam int DEF_GOOD_COUNT = 4;
   localparam int DEF_TIMEOUT    = 1024;
   localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/pll_clock_monitor_ref_edge_sync.sv
// Two-flop synchronizer plus one history flop; flags a rising edge of an
// asynchronous input three core cycles after it happens.
module ref_edge_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_rise
);

   logic r_sync1;
   logic r_sync2;
   logic r_sync3;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= i_async;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign o_rise = r_sync2 & ~r_sync3;

endmodule

// File: rtl/pll_clock_monitor.sv
// Core-clock frequency/lock monitor against the board reference clock.
// Define CLKMON_STATS_EN to keep running min/max of the window counts.
module pll_clock_monitor
   import clkmon_pkg::*;
#(
   parameter int REF_EDGES  = DEF_REF_EDGES,
   parameter int EXPECTED   = DEF_EXPECTED,
   parameter int TOLERANCE  = DEF_TOLERANCE,
   parameter int GOOD_COUNT = DEF_GOOD_COUNT,
   parameter int TIMEOUT    = DEF_TIMEOUT,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             ref_clk_in,
   input  logic             enable,
   output logic [CNT_W-1:0] meas_count,
   output logic             meas_valid,
   output logic             locked,
   output logic             sys_reset_n,
   output logic             fault,
   output logic [CNT_W-1:0] meas_min,
   output logic [CNT_W-1:0] meas_max
);

   localparam int EW = $clog2(REF_EDGES);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int GW = $clog2(GOOD_COUNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
   endfunction

   // A saturated count means the window overran the counter: never good.
   function automatic logic in_tol(input logic [CNT_W-1:0] v);
      logic signed [CNT_W:0] d;
      d = $signed({1'b0, v}) - $signed((CNT_W+1)'(EXPECTED));
      if (d < 0) d = -d;
      return (v != CNT_MAX) && (d <= $signed((CNT_W+1)'(TOLERANCE)));
   endfunction

   clkmon_state_t    r_state;
   clkmon_state_t    w_state_nxt;
   logic [CNT_W-1:0] r_cyc_cnt;
   logic [CNT_W-1:0] w_cyc_inc;
   logic [EW-1:0]    r_edge_cnt;
   logic [TW-1:0]    r_to_cnt;
   logic [GW-1:0]    r_good_cnt;
   logic [CNT_W-1:0] r_meas_count;
   logic             r_meas_valid;
   logic             r_fault;
   logic             r_sys_rst;
   logic             r_en_d;
   logic             w_ref_edge;
   logic             w_active;
   logic             w_counting;
   logic             w_close;
   logic             w_timeout;
   logic             w_good;
   logic             w_good_hit;
   logic             w_en_rise;

   ref_edge_sync u_ref_sync (
      .i_clk   (clock),
      .i_rst_n (reset_n),
      .i_async (ref_clk_in),
      .o_rise  (w_ref_edge)
   );

   assign w_active   = (r_state != IDLE);
   assign w_counting = (r_state == MEASURE) || (r_state == LOCKED);
   assign w_cyc_inc  = sat_inc(r_cyc_cnt);
   assign w_close    = w_counting && w_ref_edge && (r_edge_cnt == EW'(REF_EDGES - 1));
   assign w_timeout  = w_active && !w_ref_edge && (r_to_cnt == TW'(TIMEOUT - 1));
   assign w_good     = in_tol(w_cyc_inc);
   assign w_good_hit = w_good && (r_good_cnt >= GW'(GOOD_COUNT - 1));
   assign w_en_rise  = enable && !r_en_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   // Timeout can never coincide with a closing edge, but it still takes priority.
   always_comb begin
      w_state_nxt = r_state;
      if (!enable) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:    w_state_nxt = ARM;
            ARM:     if (w_ref_edge) w_state_nxt = MEASURE;
            MEASURE: begin
               if (w_timeout)                  w_state_nxt = ARM;
               else if (w_close && w_good_hit) w_state_nxt = LOCKED;
            end
            LOCKED: begin
               if (w_timeout)               w_state_nxt = ARM;
               else if (w_close && !w_good) w_state_nxt = MEASURE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // The closing edge of one window is the opening edge of the next.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cyc_cnt  <= '0;
         r_edge_cnt <= '0;
         r_to_cnt   <= '0;
      end else if (!enable || !w_active) begin
         r_cyc_cnt  <= '0;
         r_edge_cnt <= '0;
         r_to_cnt   <= '0;
      end else begin
         r_to_cnt <= (w_ref_edge || w_timeout) ? '0 : r_to_cnt + TW'(1);
         if (((r_state == ARM) && w_ref_edge) || w_close) begin
            r_cyc_cnt  <= '0;
            r_edge_cnt <= '0;
         end else if (w_counting) begin
            r_cyc_cnt <= w_cyc_inc;
            if (w_ref_edge) r_edge_cnt <= r_edge_cnt + EW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_good_cnt <= '0;
      end else if (!enable || w_timeout) begin
         r_good_cnt <= '0;
      end else if (w_close) begin
         if (!w_good)                              r_good_cnt <= '0;
         else if (r_good_cnt != GW'(GOOD_COUNT))   r_good_cnt <= r_good_cnt + GW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_meas_count <= '0;
         r_meas_valid <= 1'b0;
         r_fault      <= 1'b0;
         r_sys_rst    <= 1'b0;
         r_en_d       <= 1'b0;
      end else begin
         r_en_d       <= enable;
         r_sys_rst    <= (r_state == LOCKED);
         r_meas_valid <= enable && w_close;
         if (enable && w_close) r_meas_count <= w_cyc_inc;
         if (w_en_rise)
            r_fault <= 1'b0;
         else if (enable && (w_timeout || (w_close && !w_good && (r_state == LOCKED))))
            r_fault <= 1'b1;
      end
   end

   assign meas_count  = r_meas_count;
   assign meas_valid  = r_meas_valid;
   assign locked      = (r_state == LOCKED);
   assign sys_reset_n = r_sys_rst & locked;
   assign fault       = r_fault;

`ifdef CLKMON_STATS_EN
   logic [CNT_W-1:0] r_min;
   logic [CNT_W-1:0] r_max;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_min <= '1;
         r_max <= '0;
      end else if (w_en_rise) begin
         r_min <= '1;
         r_max <= '0;
      end else if (enable && w_close) begin
         if (w_cyc_inc < r_min) r_min <= w_cyc_inc;
         if (w_cyc_inc > r_max) r_max <= w_cyc_inc;
      end
   end

   assign meas_min = r_min;
   assign meas_max = r_max;
`else
   assign meas_min = '0;
   assign meas_max = '0;
`endif

endmodule

// File: tb/tb_pll_clock_monitor.sv
// Scoreboard bench for pll_clock_monitor: reference edges generated in whole
// core cycles, expected window results queued at drive time.
`timescale 1ns/1ps
module tb_pll_clock_monitor;

   localparam int CNT_W = 16;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic             ref_clk_in = 1'b0;
   logic             enable = 1'b0;
   logic [CNT_W-1:0] meas_count;
   logic             meas_valid;
   logic             locked;
   logic             sys_reset_n;
   logic             fault;
   logic [CNT_W-1:0] meas_min;
   logic [CNT_W-1:0] meas_max;

   typedef struct {
      int cnt;
      bit lck;
      bit flt;
      bit srst;
   } exp_t;

   exp_t sb_q[$];
   int   n_total = 0;
   int   n_bad = 0;
   int   m_gc = 0;
   bit   m_lck = 1'b0;
   bit   m_flt = 1'b0;
   bit   mon_on = 1'b0;
   bit   srst_chk = 1'b0;

   pll_clock_monitor #(
      .REF_EDGES  (64),
      .EXPECTED   (256),
      .TOLERANCE  (2),
      .GOOD_COUNT (4),
      .TIMEOUT    (1024),
      .CNT_W      (CNT_W)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .ref_clk_in  (ref_clk_in),
      .enable      (enable),
      .meas_count  (meas_count),
      .meas_valid  (meas_valid),
      .locked      (locked),
      .sys_reset_n (sys_reset_n),
      .fault       (fault),
      .meas_min    (meas_min),
      .meas_max    (meas_max)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, act, exp);
      end
   endtask

   task automatic model_clear(input bit flt);
      m_gc  = 0;
      m_lck = 1'b0;
      m_flt = flt;
   endtask

   task automatic push_exp(input int cnt);
      exp_t e;
      bit   good;
      bit   prev;
      good = ((cnt - 256) <= 2) && ((256 - cnt) <= 2);
      prev = m_lck;
      if (good) begin
         if (m_gc < 4) m_gc++;
      end else begin
         if (m_lck) m_flt = 1'b1;
         m_gc = 0;
      end
      m_lck  = (m_gc == 4);
      e.cnt  = cnt;
      e.lck  = m_lck;
      e.flt  = m_flt;
      e.srst = prev && m_lck;
      sb_q.push_back(e);
   endtask

   task automatic ref_open();
      @(negedge clock);
      ref_clk_in = 1'b0;
      repeat (2) @(negedge clock);
      ref_clk_in = 1'b1;
   endtask

   task automatic ref_period(input int p);
      int h;
      h = p / 2;
      repeat (h) @(negedge clock);
      ref_clk_in = 1'b0;
      repeat (p - h) @(negedge clock);
      ref_clk_in = 1'b1;
   endtask

   task automatic run_window(input int tot);
      int base;
      int rem;
      push_exp(tot);
      base = tot / 64;
      rem  = tot % 64;
      for (int i = 0; i < 64; i++) ref_period(base + ((i < rem) ? 1 : 0));
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (srst_chk) begin
            chk("srst_after_lock", sys_reset_n, 1);
            srst_chk = 1'b0;
         end
         if (mon_on && meas_valid) begin
            if (sb_q.size() == 0) begin
               chk("unexp_valid", meas_valid, 0);
            end else begin
               e = sb_q.pop_front();
               chk("meas_count", meas_count, e.cnt);
               chk("locked", locked, e.lck);
               chk("fault", fault, e.flt);
               chk("sys_reset_n", sys_reset_n, e.srst);
               if (e.lck && !e.srst) srst_chk = 1'b1;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, queue=%0d", sb_q.size());
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clock);
      chk("rst_count", meas_count, 0);
      chk("rst_valid", meas_valid, 0);
      chk("rst_locked", locked, 0);
      chk("rst_srst", sys_reset_n, 0);
      chk("rst_fault", fault, 0);
`ifdef CLKMON_STATS_EN
      chk("rst_min", meas_min, 16'hFFFF);
      chk("rst_max", meas_max, 0);
`else
      chk("tied_min", meas_min, 0);
      chk("tied_max", meas_max, 0);
`endif
      reset_n = 1'b1;
      mon_on  = 1'b1;
      @(negedge clock);
      enable = 1'b1;

      // ideal lock, loss on a 259 window, relock with fault held
      ref_open();
      repeat (9) run_window(256);
      run_window(259);
      repeat (4) run_window(256);

      // reference stops while locked
      repeat (2) @(negedge clock);
      ref_clk_in = 1'b0;
      repeat (1000) @(negedge clock);
      chk("locked_before_to", locked, 1);
      repeat (40) @(negedge clock);
      chk("locked_after_to", locked, 0);
      chk("fault_after_to", fault, 1);
      chk("srst_after_to", sys_reset_n, 0);
      model_clear(1'b1);

      // tolerance edges; 253 restarts the run
      ref_open();
      run_window(258);
      run_window(254);
      run_window(253);
      run_window(258);
      run_window(254);
      run_window(258);
      run_window(256);

      // enable toggle while locked with fault set
      repeat (6) @(negedge clock);
      chk("fault_before_toggle", fault, 1);
      enable = 1'b0;
      @(negedge clock);
      chk("locked_en0", locked, 0);
      chk("fault_en0", fault, 1);
      chk("srst_en0", sys_reset_n, 0);
      enable = 1'b1;
      @(negedge clock);
      chk("fault_reenable", fault, 0);
`ifdef CLKMON_STATS_EN
      chk("min_reinit", meas_min, 16'hFFFF);
      chk("max_reinit", meas_max, 0);
`endif
      model_clear(1'b0);
      ref_open();
      run_window(258);
      run_window(254);
      run_window(258);
      run_window(256);
      repeat (6) @(negedge clock);
`ifdef CLKMON_STATS_EN
      chk("min_track", meas_min, 254);
      chk("max_track", meas_max, 258);
`else
      chk("tied_min_run", meas_min, 0);
      chk("tied_max_run", meas_max, 0);
`endif

      // reset mid-window
      repeat (30) ref_period(4);
      @(negedge clock);
      chk("locked_pre_rst", locked, 1);
      ref_clk_in = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("arst_count", meas_count, 0);
      chk("arst_valid", meas_valid, 0);
      chk("arst_locked", locked, 0);
      chk("arst_srst", sys_reset_n, 0);
      chk("arst_fault", fault, 0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      model_clear(1'b0);
      ref_open();
      run_window(256);
      repeat (8) @(negedge clock);
      chk("sb_empty", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/pll_clock_monitor.md
# pll_clock_monitor

Frequency/lock monitor running on the PLL-generated core clock. It samples the board reference clock as an asynchronous data input and counts core-clock cycles across a fixed number of reference edges. It declares lock after consecutive in-tolerance measurements and generates the core-domain reset release for the TDC logic. It consumes the PLL output and confirms the PLL produces the frequency it was configured for.

## Interface
- REF_EDGES, 64: reference rising edges per measurement window (≥2)
- EXPECTED, 256: expected core cycles per window (48 MHz core / 12 MHz ref × 64)
- TOLERANCE, 2: allowed absolute deviation from EXPECTED
- GOOD_COUNT, 4: consecutive good windows required for lock (≥1)
- TIMEOUT, 1024: core cycles without a reference edge before ref-missing fault
- CNT_W, 16: measurement counter width
- clock  in  1  PLL core clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- ref_clk_in  in  1  board reference clock, treated as asynchronous data
- enable  in  1  monitor enable
- meas_count  out  CNT_W  last completed window count
- meas_valid  out  1  one-cycle pulse when meas_count updates
- locked  out  1  lock indication
- sys_reset_n  out  1  core-domain reset release for downstream logic
- fault  out  1  sticky: lock lost or reference missing
- meas_min, meas_max  out  CNT_W  extreme counts since enable (see Configuration)

## Operation
- ref_clk_in passes a 2-FF synchronizer plus one edge FF. ref_edge = sync2 & ~sync3. The edge pulse is 3 cycles behind the input edge.
- States:
  - IDLE: entered on reset or enable=0.
  - ARM: waiting for the opening edge.
  - MEASURE: counting.
  - LOCKED: counting with lock asserted.
- IDLE→ARM when enable=1. ARM→MEASURE on ref_edge; cycle counter and edge counter clear.
- In MEASURE/LOCKED, cycle counter increments every cycle and saturates at 2^CNT_W−1. The edge counter increments on ref_edge.
- The REF_EDGES-th edge closes the window and opens the next, with no dead time. Count = cycles after the opening-edge cycle through the closing-edge cycle inclusive.
- Good window: |count − EXPECTED| ≤ TOLERANCE. Difference computed signed at CNT_W+1 bits; a saturated count is always bad.
- Consecutive-good counter increments on a good window (saturating at GOOD_COUNT) and clears on a bad one.
- MEASURE→LOCKED when the counter reaches GOOD_COUNT.
- LOCKED→MEASURE on any bad window: consecutive-good clears and fault sets.
- Ref-missing: a timeout counter clears on each ref_edge. Reaching TIMEOUT in ARM/MEASURE/LOCKED sets fault, clears consecutive-good, and goes to ARM. No meas_valid is generated for a timeout.
- enable=0 in any state: to IDLE next cycle, counters clear, locked=0. fault holds.
- fault clears only on reset or an enable 0→1 transition.
- Bad window and timeout in the same cycle: timeout wins (→ARM).

## Timing
- Reset values:
  - meas_count=0, meas_valid=0, locked=0, sys_reset_n=0, fault=0
  - meas_min=all ones, meas_max=0
- meas_count/meas_valid register one cycle after the closing ref_edge cycle.
- locked rises in the same cycle as the meas_valid of the GOOD_COUNT-th good window. It falls in the same cycle as the meas_valid of a bad window, or one cycle after timeout/enable=0.
- sys_reset_n is registered: it rises one cycle after locked rises. It falls combinationally with locked (AND with locked) so downstream reset asserts without delay.
- Minimum time to lock from enable: 3 sync + arm edge + GOOD_COUNT×window.

## Configuration
- CLKMON_STATS_EN defined:
  - meas_min/meas_max update on each meas_valid (min/max against the new count).
  - Both reinitialise on enable 0→1.
- Undefined: meas_min/meas_max tied to 0 and no registers are inferred.

## Structure
- Shared package clkmon_pkg holds:
  - state enum (IDLE, ARM, MEASURE, LOCKED)
  - default parameter constants for the 12 MHz→48 MHz build
- Natural sub-module: ref_edge_sync (2-FF synchronizer + rising-edge detector, async active-low reset, output 0 at reset).

## Test plan
- Ideal 48 MHz core / 12 MHz ref, enable at t0 -> each meas_count=256; locked and fault=0 after 4th meas_valid; sys_reset_n high one cycle later.
- Ref period giving count 259 in window 6 after lock -> locked and sys_reset_n drop with that meas_valid; fault=1; relock after 4 more good windows; fault stays 1.
- Counts 258, 254, 258, 256 -> all good (±2 inclusive), lock after 4th; a 253 before the 4th restarts the consecutive count.
- Ref held low 1024 cycles while LOCKED -> locked=0, fault=1, state ARM, no meas_valid; ref restarts -> lock after 4 good windows.
- enable toggled 1→0→1 while LOCKED with fault=1 -> locked=0 next cycle; fault cleared on re-enable; with CLKMON_STATS_EN, min/max reinitialised and then track 254/258.
- reset_n pulsed mid-window -> all outputs at reset values immediately; first meas_valid only after a fresh full window.
